vga_sweep: RTL and testbench
============================

VGA_SWEEP -- requirements
Module: vga_sweep

Interface
REQ-001 SHALL have parameter H_VIS, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, hsync width in pixels.
REQ-004 SHALL have parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_VIS, default 480, visible lines per frame.
REQ-006 SHALL have parameter V_FP, default 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2, vsync width in lines.
REQ-008 SHALL have parameter V_BP, default 33, vertical back porch in lines.
REQ-009 SHALL have port clk, input, 1 bit: 100 MHz system clock; one clock, all state on its rising edge.
REQ-010 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-011 SHALL have port speed, input, 4 bits: frames per ball step; 0 is treated as 1.
REQ-012 SHALL have port pause, input, 1 bit: suppresses move pulses.
REQ-013 SHALL have port pixpulse, output, 1 bit: pixel-rate enable, one clk wide, every 4 clocks (25 MHz).
REQ-014 SHALL have ports hcount and vcount, outputs, 10 bits each: current pixel column and line.
REQ-015 SHALL have ports hsync and vsync, outputs, 1 bit each: active-low syncs.
REQ-016 SHALL have port blank, output, 1 bit: high outside the visible area.
REQ-017 SHALL have port move, output, 1 bit: ball position update strobe.
REQ-018 SHALL have port frame_tick, output, 1 bit: start-of-vertical-blank marker.

Function
REQ-019 SHALL run a 2-bit divider that increments every clk and wraps 3->0; pixpulse SHALL be high exactly in cycles where divider==3.
REQ-020 SHALL hold hcount/vcount for a whole pixel period and advance both only on the clk edge ending a pixpulse cycle.
REQ-021 SHALL wrap hcount from H_TOT-1 to 0, where H_TOT = H_VIS+H_FP+H_SYNC+H_BP = 800.
REQ-022 SHALL advance vcount only when hcount wraps, and wrap vcount from V_TOT-1 to 0 (V_TOT = 525).
REQ-023 SHALL drive hsync low iff H_VIS+H_FP <= hcount < H_VIS+H_FP+H_SYNC, i.e. 656..751.
REQ-024 SHALL drive vsync low iff V_VIS+V_FP <= vcount < V_VIS+V_FP+V_SYNC, i.e. 490..491.
REQ-025 SHALL assert blank iff hcount >= H_VIS or vcount >= V_VIS.
REQ-026 SHALL keep hsync, vsync and blank consistent with the hcount/vcount values presented in the same cycle, with zero skew, using registered outputs.
REQ-027 SHALL assert frame_tick for exactly the one pixpulse cycle where hcount==0 and vcount==V_VIS.
REQ-028 SHALL handle move with a 4-bit frame counter fcnt and an effective speed spd_eff = max(speed,1), with speed sampled on each frame_tick cycle:
- At frame_tick with pause=1: no move, fcnt holds.
- At frame_tick with pause=0 and fcnt >= spd_eff-1: move is asserted in that same cycle and fcnt clears to 0.
- Otherwise: fcnt increments.
REQ-029 SHALL keep move one clk wide, coincident with pixpulse, and never asserted outside a frame_tick cycle, so the downstream ball stage updates once, inside vertical blank.
REQ-030 SHALL apply a speed reduction below fcnt+1 at the next frame_tick, producing a move there; no counter overflow or lockup.

Reset
REQ-031 SHALL, while rst is high, force divider=0, pixpulse=0, hcount=0, vcount=0, hsync=1, vsync=1, blank=0, move=0, frame_tick=0, fcnt=0, asynchronously.
REQ-032 SHALL, after a mid-frame reset release, restart from pixel (0,0) with no move or frame_tick until vcount next reaches V_VIS.
REQ-033 SHALL, on release, raise the first pixpulse in clk cycle 4 after release (cycle 1 = first edge with rst low), with hcount=0 and vcount=0.

Verification
REQ-034 Release reset, speed=1, pause=0 -> pixpulse in cycles 4, 8, 12, ...; hcount=1 during cycle-8 pixpulse; hcount=799 then 0 with vcount 0->1 at cycle 3204.
REQ-035 Free run, one frame -> hsync low for 96 pixels from hcount=656; vsync low on lines 490-491; blank high for hcount>=640 or vcount>=480; frame period 1,680,000 clocks.
REQ-036 speed=1 -> move and frame_tick both high in cycle 1,536,004, then every 1,680,000 clocks, each 1 clk wide.
REQ-037 speed=2 -> frame_tick at 1,536,004 with no move; move at 3,216,004; speed=0 -> same as speed=1.
REQ-038 pause=1 across two frame_ticks, then 0 with speed=3 -> no moves while paused, fcnt unchanged; first move on third unpaused frame_tick.
REQ-039 rst pulsed at hcount=300, vcount=200 -> all outputs return to reset values immediately; next frame_tick 1,536,004 cycles after release.

Source files
------------

// File: rtl/vga_sweep_if.sv
// Bundles the timing-generator bus: speed/pause control in,
// pixel timing, sync, blank and ball-step strobes out.
interface vga_sweep_if;
  logic [3:0] speed;
  logic       pause;
  logic       pixpulse;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       hsync;
  logic       vsync;
  logic       blank;
  logic       move;
  logic       frame_tick;

  modport master (
    output speed, pause,
    input  pixpulse, hcount, vcount, hsync, vsync, blank, move, frame_tick
  );

  modport slave (
    input  speed, pause,
    output pixpulse, hcount, vcount, hsync, vsync, blank, move, frame_tick
  );
endinterface

// File: rtl/vga_sweep.sv
// VGA raster timing generator with a ball-step strobe.
// A 2-bit divider makes a 25 MHz pixel enable from clk; counters, syncs and
// blank advance together on the edge that ends a pixel period so all
// registered outputs stay aligned with hcount/vcount. Once per frame, at the
// start of vertical blank, a frame counter decides whether to emit move.
module vga_sweep #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic        clk,
  input  logic        rst,
  vga_sweep_if.slave  bus
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
  localparam logic [9:0] H_VIS_W  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_W  = 10'(V_VIS);
  localparam logic [9:0] HS_START = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);

  logic [1:0] r_div;
  logic       r_pix;
  logic [9:0] r_h;
  logic [9:0] r_v;
  logic       r_hs;
  logic       r_vs;
  logic       r_blank;
  logic       r_move;
  logic       r_ft;
  logic [3:0] r_fcnt;

  logic       w_adv;
  logic [9:0] w_h_nxt;
  logic [9:0] w_v_nxt;
  logic       w_tick_nxt;
  logic [3:0] w_spd_m1;
  logic       w_step_due;

  // Edge ending a pixpulse cycle is the only edge where the raster advances.
  assign w_adv = (r_div == 2'd3);

  // Next raster position; decoding syncs/blank from it keeps zero skew.
  always_comb begin
    w_h_nxt = r_h + 10'd1;
    w_v_nxt = r_v;
    if (r_h == H_LAST) begin
      w_h_nxt = 10'd0;
      w_v_nxt = (r_v == V_LAST) ? 10'd0 : r_v + 10'd1;
    end
  end

  // frame_tick is registered into the pixpulse cycle sitting on (0, V_VIS);
  // speed 0 behaves as 1, so the threshold is max(speed,1)-1.
  always_comb begin
    w_tick_nxt = (r_div == 2'd2) && (r_h == 10'd0) && (r_v == V_VIS_W);
    w_spd_m1   = (bus.speed == 4'd0) ? 4'd0 : bus.speed - 4'd1;
    w_step_due = (r_fcnt >= w_spd_m1);
  end

  // Pixel divider and pixel enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= 2'd0;
      r_pix <= 1'b0;
    end else begin
      r_div <= r_div + 2'd1;
      r_pix <= (r_div == 2'd2);
    end
  end

  // Raster counters with their sync/blank decodes, updated as one group.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h     <= 10'd0;
      r_v     <= 10'd0;
      r_hs    <= 1'b1;
      r_vs    <= 1'b1;
      r_blank <= 1'b0;
    end else if (w_adv) begin
      r_h     <= w_h_nxt;
      r_v     <= w_v_nxt;
      r_hs    <= !((w_h_nxt >= HS_START) && (w_h_nxt < HS_END));
      r_vs    <= !((w_v_nxt >= VS_START) && (w_v_nxt < VS_END));
      r_blank <= (w_h_nxt >= H_VIS_W) || (w_v_nxt >= V_VIS_W);
    end
  end

  // Frame tick, move strobe and frame counter; fcnt clears on every move so
  // it can never exceed 14 and a lowered speed takes effect at the next tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ft   <= 1'b0;
      r_move <= 1'b0;
      r_fcnt <= 4'd0;
    end else begin
      r_ft   <= w_tick_nxt;
      r_move <= w_tick_nxt && !bus.pause && w_step_due;
      if (w_tick_nxt && !bus.pause) begin
        r_fcnt <= w_step_due ? 4'd0 : r_fcnt + 4'd1;
      end
    end
  end

  assign bus.pixpulse   = r_pix;
  assign bus.hcount     = r_h;
  assign bus.vcount     = r_v;
  assign bus.hsync      = r_hs;
  assign bus.vsync      = r_vs;
  assign bus.blank      = r_blank;
  assign bus.move       = r_move;
  assign bus.frame_tick = r_ft;

endmodule

// File: tb/tb_vga_sweep.sv
// Bench for vga_sweep using a shrunken raster so several frames fit in a
// short run. The reference derives every output from the number of clock
// edges since reset release plus a per-frame move counter.
module tb_vga_sweep;

  localparam int H_VIS = 8, H_FP = 2, H_SYNC = 3, H_BP = 2;
  localparam int V_VIS = 6, V_FP = 1, V_SYNC = 2, V_BP = 2;
  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int FRAME = 4 * H_TOT * V_TOT;
  localparam int FIRST_TICK = 4 * H_TOT * V_VIS + 3;
  localparam logic [26:0] RST_VEC = {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_sweep_if u_if ();

  vga_sweep #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(u_if)
  );

  logic [26:0] obs;
  assign obs = {u_if.pixpulse, u_if.hcount, u_if.vcount, u_if.hsync, u_if.vsync,
                u_if.blank, u_if.move, u_if.frame_tick};

  int checks = 0;
  int errors = 0;
  int n = 0;
  int m_fcnt = 0;
  int m_h = 0;
  int m_v = 0;
  logic [26:0] exp_vec = RST_VEC;

  // Expected outputs after edge n, from raster arithmetic.
  task automatic model_step();
    int p, spd;
    logic pp, hs, vs, bl, ft, mv;
    n++;
    p   = n / 4;
    m_h = p % H_TOT;
    m_v = (p / H_TOT) % V_TOT;
    pp  = (n % 4) == 3;
    ft  = pp && (m_h == 0) && (m_v == V_VIS);
    mv  = 1'b0;
    if (ft && !u_if.pause) begin
      spd = (u_if.speed == 4'd0) ? 1 : int'(u_if.speed);
      if (m_fcnt >= spd - 1) begin
        mv = 1'b1;
        m_fcnt = 0;
      end else begin
        m_fcnt++;
      end
    end
    hs = !((m_h >= H_VIS + H_FP) && (m_h < H_VIS + H_FP + H_SYNC));
    vs = !((m_v >= V_VIS + V_FP) && (m_v < V_VIS + V_FP + V_SYNC));
    bl = (m_h >= H_VIS) || (m_v >= V_VIS);
    exp_vec = {pp, 10'(m_h), 10'(m_v), hs, vs, bl, mv, ft};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    m_fcnt = 0;
  endtask

  task automatic test_reset();
    int first_pp;
    u_if.speed = 4'd1;
    u_if.pause = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs !== RST_VEC) begin
      errors++;
      $display("FAIL reset_hold got=%h exp=%h", obs, RST_VEC);
    end
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    m_fcnt = 0;
    first_pp = -1;
    repeat (4 * H_TOT + 8) begin
      tick();
      if (u_if.pixpulse && first_pp < 0) first_pp = n;
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL reset_start n=%0d got=%h exp=%h", n, obs, exp_vec);
      end
    end
    checks++;
    if (first_pp != 3) begin
      errors++;
      $display("FAIL first_pixpulse edge got=%0d exp=3", first_pp);
    end
  endtask

  task automatic test_speed1();
    int ticks[$];
    int moves[$];
    u_if.speed = 4'd1;
    u_if.pause = 1'b0;
    do_reset();
    repeat (3 * FRAME) begin
      tick();
      if (u_if.frame_tick) ticks.push_back(n);
      if (u_if.move) moves.push_back(n);
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL speed1 n=%0d got=%h exp=%h", n, obs, exp_vec);
      end
    end
    checks++;
    if (ticks.size() != 3 || ticks[0] != FIRST_TICK || ticks[1] != FIRST_TICK + FRAME) begin
      errors++;
      $display("FAIL speed1_ticks count=%0d first=%0d exp first=%0d period=%0d",
               ticks.size(), (ticks.size() > 0) ? ticks[0] : -1, FIRST_TICK, FRAME);
    end
    checks++;
    if (moves.size() != 3 || moves[0] != FIRST_TICK) begin
      errors++;
      $display("FAIL speed1_moves count=%0d exp=3", moves.size());
    end
  endtask

  task automatic test_speed2_zero();
    int first_mv;
    u_if.speed = 4'd2;
    u_if.pause = 1'b0;
    do_reset();
    first_mv = -1;
    repeat (3 * FRAME) begin
      tick();
      if (u_if.move && first_mv < 0) first_mv = n;
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL speed2 n=%0d got=%h exp=%h", n, obs, exp_vec);
      end
    end
    checks++;
    if (first_mv != FIRST_TICK + FRAME) begin
      errors++;
      $display("FAIL speed2_first_move got=%0d exp=%0d", first_mv, FIRST_TICK + FRAME);
    end
    u_if.speed = 4'd0;
    repeat (2 * FRAME) begin
      tick();
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL speed0 n=%0d got=%h exp=%h", n, obs, exp_vec);
      end
    end
  endtask

  task automatic test_pause();
    int first_mv;
    int paused_moves;
    u_if.speed = 4'd3;
    u_if.pause = 1'b1;
    do_reset();
    paused_moves = 0;
    repeat (2 * FRAME) begin
      tick();
      if (u_if.move) paused_moves++;
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL pause n=%0d got=%h exp=%h", n, obs, exp_vec);
      end
    end
    checks++;
    if (paused_moves != 0) begin
      errors++;
      $display("FAIL pause_moves got=%0d exp=0", paused_moves);
    end
    u_if.pause = 1'b0;
    first_mv = -1;
    repeat (4 * FRAME) begin
      tick();
      if (u_if.move && first_mv < 0) first_mv = n;
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL unpause n=%0d got=%h exp=%h", n, obs, exp_vec);
      end
    end
    checks++;
    if (first_mv != FIRST_TICK + 4 * FRAME) begin
      errors++;
      $display("FAIL unpause_first_move got=%0d exp=%0d", first_mv, FIRST_TICK + 4 * FRAME);
    end
  endtask

  task automatic test_random();
    u_if.speed = 4'($urandom_range(0, 15));
    u_if.pause = 1'b0;
    repeat (16 * FRAME) begin
      tick();
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL random n=%0d spd=%0d pause=%0b got=%h exp=%h",
                 n, u_if.speed, u_if.pause, obs, exp_vec);
      end
      if ($urandom_range(0, 299) == 0) u_if.speed = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 999) == 0) u_if.pause = ~u_if.pause;
    end
  endtask

  task automatic test_midframe_reset();
    int budget;
    int first_tick;
    u_if.speed = 4'd1;
    u_if.pause = 1'b0;
    budget = 0;
    while (!(m_h == 5 && m_v == 3 && (n % 4) == 1) && budget < 2 * FRAME) begin
      tick();
      budget++;
    end
    checks++;
    if (budget >= 2 * FRAME) begin
      errors++;
      $display("FAIL midreset_reach budget expired h=%0d v=%0d", m_h, m_v);
    end
    checks++;
    if (obs !== exp_vec) begin
      errors++;
      $display("FAIL midreset_pre got=%h exp=%h", obs, exp_vec);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== RST_VEC) begin
      errors++;
      $display("FAIL midreset_async got=%h exp=%h", obs, RST_VEC);
    end
    @(posedge clk);
    #1;
    checks++;
    if (obs !== RST_VEC) begin
      errors++;
      $display("FAIL midreset_hold got=%h exp=%h", obs, RST_VEC);
    end
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    m_fcnt = 0;
    first_tick = -1;
    repeat (2 * FRAME) begin
      tick();
      if (u_if.frame_tick && first_tick < 0) first_tick = n;
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL midreset_run n=%0d got=%h exp=%h", n, obs, exp_vec);
      end
    end
    checks++;
    if (first_tick != FIRST_TICK) begin
      errors++;
      $display("FAIL midreset_first_tick got=%0d exp=%0d", first_tick, FIRST_TICK);
    end
  endtask

  initial begin
    u_if.speed = 4'd1;
    u_if.pause = 1'b0;
    test_reset();
    test_speed1();
    test_speed2_zero();
    test_pause();
    test_random();
    test_midframe_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
